// File: rtl/ram_stream_reader_if.sv
// Valid/ready stream carrying RAM words from ram_stream_reader to a consumer.
//   out_data  : stream word (master -> slave)
//   out_valid : word present (master -> slave)
//   out_ready : consumer can accept (slave -> master)
interface ram_stream_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/ram_stream_reader.sv
// Sweeps the address window [base_addr, base_addr+length) of a registered-read
// dual-port RAM and presents the returned words, in address order, as a
// valid/ready stream. A 4-entry FIFO plus credit accounting over the 2-deep
// read pipeline absorbs arbitrary backpressure without loss or duplication.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : begin a sweep (sampled only while idle)
//   base_addr    : first address, length : word count 0..DEPTH
//   busy, done   : sweep in progress / one-cycle completion pulse
//   read_address : registered address to the RAM read port
//   ram_data     : RAM data_out (valid one clock after read_address)
//   stream       : out_data / out_valid / out_ready stream master
module ram_stream_reader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10,
  parameter int DEPTH         = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0]    ram_data,
  ram_stream_reader_if.master      stream
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [ADDRESS_WIDTH:0] length_q;
  logic [ADDRESS_WIDTH:0] issued;
  logic [ADDRESS_WIDTH:0] accepted;
  logic                   p1;
  logic                   p2;
  logic [DATA_WIDTH-1:0]  fifo_mem [4];
  logic [1:0]             wr_ptr;
  logic [1:0]             rd_ptr;
  logic [2:0]             fifo_count;
  logic [3:0]             credit;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic [ADDRESS_WIDTH-1:0] next_address;

  // Words already buffered plus words still in flight must fit the FIFO.
  always_comb begin
    credit = 4'(fifo_count) + 4'(p1) + 4'(p2);
    issue  = (state == RUN) && (issued < length_q) && (credit < 4'd4);
    push   = p2;
    pop    = stream.out_valid && stream.out_ready;
    next_address = (read_address == ADDRESS_WIDTH'(DEPTH - 1)) ? '0
                                                                : read_address + 1'b1;
  end

  assign stream.out_valid = (fifo_count != 3'd0);
  assign stream.out_data  = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      read_address <= '0;
      length_q     <= '0;
      issued       <= '0;
      accepted     <= '0;
      p1           <= 1'b0;
      p2           <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      for (int unsigned i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      done <= 1'b0;
      p1   <= 1'b0;
      p2   <= p1;

      case (state)
        IDLE: begin
          if (start) begin
            length_q <= length;
            accepted <= '0;
            if (length == '0) begin
              issued <= '0;
              state  <= DONE;
              done   <= 1'b1;
            end else begin
              // The first read is issued on the start edge itself so that the
              // first word is streaming two edges later.
              read_address <= base_addr;
              issued       <= {{ADDRESS_WIDTH{1'b0}}, 1'b1};
              p1           <= 1'b1;
              busy         <= 1'b1;
              state        <= RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            read_address <= next_address;
            issued       <= issued + 1'b1;
            p1           <= 1'b1;
          end
          if (pop) begin
            accepted <= accepted + 1'b1;
            if (accepted + 1'b1 == length_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (push) begin
        fifo_mem[wr_ptr] <= ram_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
module tb_ram_stream_reader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] length;
  logic        busy;
  logic        done;
  logic [9:0]  read_address;
  logic [31:0] ram_data;

  logic [31:0] mem [1024];
  logic [31:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_count = 0;
  int xfer_count = 0;
  int last_xfer_cyc = 0;
  int ready_mode = 0;
  int stall_left = 0;
  bit stalled = 1'b0;
  logic [31:0] held_data;

  ram_stream_reader_if #(.DATA_WIDTH(32)) s_if ();

  ram_stream_reader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(10), .DEPTH(1024)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .read_address (read_address),
    .ram_data     (ram_data),
    .stream       (s_if.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Registered-read RAM model.
  always @(posedge clk) ram_data <= mem[read_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Consumer ready: always high, or pseudo-random with 10-cycle low stretches.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) begin
      s_if.out_ready = 1'b1;
    end else if (stall_left > 0) begin
      s_if.out_ready = 1'b0;
      stall_left--;
    end else begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        stall_left     = 9;
        s_if.out_ready = 1'b0;
      end else begin
        s_if.out_ready = (r > 4);
      end
    end
  end

  // Monitor: pops the scoreboard on every transfer, checks stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      check("fifo_count_le4", 32'(dut.fifo_count <= 3'd4), 32'd1);
      if (stalled) begin
        check("stall_valid", 32'(s_if.out_valid), 32'd1);
        check("stall_data", s_if.out_data, held_data);
      end
      if (s_if.out_valid && s_if.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", s_if.out_data, 32'hxxxx_xxxx);
        end else begin
          check("data", s_if.out_data, exp_q.pop_front());
        end
        xfer_count++;
        last_xfer_cyc = cyc;
      end
      if (done) done_count++;
      stalled   = s_if.out_valid && !s_if.out_ready;
      held_data = s_if.out_data;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic kick(input int base, input int len);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = 10'(base);
    length    = 11'(len);
    for (int k = 0; k < len; k++) begin
      logic [9:0] a;
      a = 10'(base + k);
      exp_q.push_back(32'(a) + 32'h100);
    end
    done_count = 0;
    xfer_count = 0;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'(len != 0));
    check("done_after_start", 32'(done), 32'(len == 0));
    if (len != 0) check("first_read_address", 32'(read_address), 32'(base));
  endtask

  task automatic wait_done(input int len);
    int n;
    bit seen;
    n = 0;
    seen = done;
    while (!seen && n < 20 * len + 100) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen && len > 0) check("done_after_last_xfer", 32'(cyc), 32'(last_xfer_cyc + 1));
    check("busy_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("done_pulses", 32'(done_count), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("xfer_count", 32'(xfer_count), 32'(len));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) + 32'h100;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    s_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_read_address", 32'(read_address), 32'd0);
    check("rst_out_valid", 32'(s_if.out_valid), 32'd0);
    check("rst_out_data", s_if.out_data, 32'd0);
    rst_n = 1'b1;

    // Basic sweep with latency and back-to-back throughput.
    kick(5, 8);
    check("lat_e0_valid", 32'(s_if.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_e1_valid", 32'(s_if.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_e2_valid", 32'(s_if.out_valid), 32'd1);
    check("lat_e2_data", s_if.out_data, 32'h105);
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      check("stream_consecutive", 32'(s_if.out_valid), 32'd1);
    end
    wait_done(8);

    // Backpressure.
    ready_mode = 1;
    kick(0, 16);
    wait_done(16);
    ready_mode = 0;

    // Wrap-around.
    kick(1020, 8);
    wait_done(8);

    // Edge lengths.
    kick(0, 0);
    check("len0_no_valid", 32'(s_if.out_valid), 32'd0);
    wait_done(0);
    kick(7, 1);
    wait_done(1);
    kick(0, 1024);
    wait_done(1024);

    // Start while busy is ignored.
    ready_mode = 1;
    kick(100, 12);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 10'd500;
    length = 11'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(12);
    ready_mode = 0;

    // Reset mid-sweep after three accepted words.
    kick(0, 10);
    begin
      int n;
      n = 0;
      while (xfer_count < 3 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("xfers_before_reset", 32'(xfer_count), 32'd3);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_valid", 32'(s_if.out_valid), 32'd0);
    check("mid_rst_read_address", 32'(read_address), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    kick(0, 4);
    wait_done(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
